// File: rtl/bram_stream_reader.sv
// Streams a run of BRAM words out over a valid/ready handshake.
// Optional trailing checksum word: define BRAM_STREAM_READER_CHECKSUM_EN.
module bram_stream_reader #(
  parameter int WIDTH = 8,
  localparam int DEPTH = 4096 / WIDTH,
  localparam int ADDRW = $clog2(DEPTH)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [ADDRW-1:0] base_in,
  input  logic [ADDRW:0]   len_in,
  output logic [ADDRW-1:0] mem_addr_out,
  input  logic [WIDTH-1:0] mem_data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic             busy_out,
  output logic             done_out
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SEND,
`ifdef BRAM_STREAM_READER_CHECKSUM_EN
    CSUM,
`endif
    DONE
  } state_t;

  state_t           state;
  logic [ADDRW-1:0] addr;
  logic [ADDRW:0]   remain;
`ifdef BRAM_STREAM_READER_CHECKSUM_EN
  logic [WIDTH-1:0] sum;
`endif

  // The BRAM read port is combinational; addr is always a clean register.
  assign mem_addr_out = addr;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= IDLE;
      addr      <= '0;
      remain    <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      busy_out  <= 1'b0;
      done_out  <= 1'b0;
`ifdef BRAM_STREAM_READER_CHECKSUM_EN
      sum       <= '0;
`endif
    end else begin
      done_out <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_in) begin
            busy_out <= 1'b1;
`ifdef BRAM_STREAM_READER_CHECKSUM_EN
            sum <= '0;
`endif
            if (len_in != '0) begin
              addr   <= base_in;
              remain <= len_in;
              state  <= FETCH;
            end else begin
`ifdef BRAM_STREAM_READER_CHECKSUM_EN
              data_out  <= '0;
              valid_out <= 1'b1;
              state     <= CSUM;
`else
              done_out <= 1'b1;
              state    <= DONE;
`endif
            end
          end
        end
        FETCH: begin
          data_out  <= mem_data_in;
          valid_out <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          if (ready_in) begin
            valid_out <= 1'b0;
`ifdef BRAM_STREAM_READER_CHECKSUM_EN
            sum <= sum + data_out;
`endif
            if (remain == (ADDRW+1)'(1)) begin
`ifdef BRAM_STREAM_READER_CHECKSUM_EN
              data_out  <= sum + data_out;
              valid_out <= 1'b1;
              state     <= CSUM;
`else
              done_out <= 1'b1;
              state    <= DONE;
`endif
            end else begin
              addr   <= addr + 1'b1;
              remain <= remain - 1'b1;
              state  <= FETCH;
            end
          end
        end
`ifdef BRAM_STREAM_READER_CHECKSUM_EN
        CSUM: begin
          if (ready_in) begin
            valid_out <= 1'b0;
            done_out  <= 1'b1;
            state     <= DONE;
          end
        end
`endif
        DONE: begin
          busy_out <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state    <= IDLE;
          busy_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader: per-cycle vector table
// plus stall, reset-abort and address-wrap sequences.
module tb_bram_stream_reader;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4096 / WIDTH;
  localparam int ADDRW = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [ADDRW-1:0] base;
  logic [ADDRW:0]   len;
  logic [ADDRW-1:0] mem_addr;
  logic [WIDTH-1:0] mem_data;
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;
  logic             busy;
  logic             done;

  logic [WIDTH-1:0] mem [DEPTH];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign mem_data = mem[mem_addr];

  bram_stream_reader #(.WIDTH(WIDTH)) dut (
    .clk_in       (clk),
    .rst_in       (rst),
    .start_in     (start),
    .base_in      (base),
    .len_in       (len),
    .mem_addr_out (mem_addr),
    .mem_data_in  (mem_data),
    .data_out     (data),
    .valid_out    (valid),
    .ready_in     (ready),
    .busy_out     (busy),
    .done_out     (done)
  );

  typedef struct {
    logic             start;
    logic [ADDRW-1:0] base;
    logic [ADDRW:0]   len;
    logic             ready;
    logic             valid;
    logic [WIDTH-1:0] data;
    logic             busy;
    logic             done;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, output int cycles,
                            output bit ok);
    cycles = 0;
    ok = 1'b0;
    while (cycles < 10) begin
      if (valid) begin
        ok = 1'b1;
        break;
      end
      tick();
      cycles++;
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: valid timeout got 0 expected 1", name);
    end
  endtask

  // Start a transfer of up to 4 words, optionally stalling word `stall`.
  task automatic stream(input string name, input logic [ADDRW-1:0] b,
                        input logic [ADDRW:0] l, input int stall,
                        input logic [WIDTH-1:0] e0, input logic [WIDTH-1:0] e1,
                        input logic [WIDTH-1:0] e2, input logic [WIDTH-1:0] e3);
    logic [WIDTH-1:0] exp [4];
    int cyc;
    bit ok;
    exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
    ready = 1'b0;
    start = 1'b1;
    base  = b;
    len   = l;
    tick();
    start = 1'b0;
    for (int i = 0; i < int'(l); i++) begin
      wait_valid(name, cyc, ok);
      if (!ok) return;
      if (i == 0) chk({name, " first-valid latency"}, cyc, 1);
      if (i == stall) begin
        for (int k = 0; k < 5; k++) begin
          tick();
          chk({name, " stall valid"}, valid, 1'b1);
          chk({name, " stall data"}, data, exp[i]);
        end
      end
      chk({name, " data"}, data, exp[i]);
      ready = 1'b1;
      tick();
      ready = 1'b0;
    end
    chk({name, " done pulse"}, done, 1'b1);
    chk({name, " valid after last"}, valid, 1'b0);
    tick();
    chk({name, " done cleared"}, done, 1'b0);
    chk({name, " busy cleared"}, busy, 1'b0);
  endtask

  function automatic vec_t mk(input logic s, input logic [ADDRW-1:0] b,
                              input logic [ADDRW:0] l, input logic r,
                              input logic v, input logic [WIDTH-1:0] d,
                              input logic bz, input logic dn);
    vec_t x;
    x.start = s; x.base = b; x.len = l; x.ready = r;
    x.valid = v; x.data = d; x.busy = bz; x.done = dn;
    return x;
  endfunction

  initial begin
    int cyc;
    bit ok;
    for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(i * 7 + 3);
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;

    // len=4 burst, then len=0, then len=3 with ignored restarts.
    vecs[0]  = mk(1, 0, 4, 1, 0, 8'h00, 1, 0);
    vecs[1]  = mk(0, 0, 0, 1, 1, 8'h11, 1, 0);
    vecs[2]  = mk(0, 0, 0, 1, 0, 8'h11, 1, 0);
    vecs[3]  = mk(0, 0, 0, 1, 1, 8'h22, 1, 0);
    vecs[4]  = mk(0, 0, 0, 1, 0, 8'h22, 1, 0);
    vecs[5]  = mk(0, 0, 0, 1, 1, 8'h33, 1, 0);
    vecs[6]  = mk(0, 0, 0, 1, 0, 8'h33, 1, 0);
    vecs[7]  = mk(0, 0, 0, 1, 1, 8'h44, 1, 0);
    vecs[8]  = mk(0, 0, 0, 1, 0, 8'h44, 1, 1);
    vecs[9]  = mk(0, 0, 0, 1, 0, 8'h44, 0, 0);
    vecs[10] = mk(1, 0, 0, 1, 0, 8'h44, 1, 1);
    vecs[11] = mk(0, 0, 0, 1, 0, 8'h44, 0, 0);
    vecs[12] = mk(1, 0, 3, 1, 0, 8'h44, 1, 0);
    vecs[13] = mk(1, 5, 1, 1, 1, 8'h11, 1, 0);
    vecs[14] = mk(1, 5, 1, 1, 0, 8'h11, 1, 0);
    vecs[15] = mk(0, 0, 0, 1, 1, 8'h22, 1, 0);
    vecs[16] = mk(0, 0, 0, 1, 0, 8'h22, 1, 0);
    vecs[17] = mk(0, 0, 0, 1, 1, 8'h33, 1, 0);
    vecs[18] = mk(0, 0, 0, 1, 0, 8'h33, 1, 1);
    vecs[19] = mk(0, 0, 0, 1, 0, 8'h33, 0, 0);

    rst = 1'b1; start = 1'b0; base = '0; len = '0; ready = 1'b0;
    tick();
    tick();
    chk("reset valid", valid, 1'b0);
    chk("reset data", data, 8'h00);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset addr", mem_addr, 0);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      start = vecs[i].start;
      base  = vecs[i].base;
      len   = vecs[i].len;
      ready = vecs[i].ready;
      tick();
      if (valid !== vecs[i].valid || data !== vecs[i].data ||
          busy !== vecs[i].busy || done !== vecs[i].done) begin
        $display("FAIL vec[%0d]: got v=%b d=%0h b=%b dn=%b expected v=%b d=%0h b=%b dn=%b",
                 i, valid, data, busy, done, vecs[i].valid, vecs[i].data,
                 vecs[i].busy, vecs[i].done);
        n_fail++;
      end
      n_chk++;
    end
    start = 1'b0;
    ready = 1'b0;

    stream("stall", 0, 4, 2, 8'h11, 8'h22, 8'h33, 8'h44);

    // Abort with reset while word 1 of 4 is being offered.
    start = 1'b1; base = 0; len = 4;
    tick();
    start = 1'b0;
    wait_valid("abort w0", cyc, ok);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    wait_valid("abort w1", cyc, ok);
    chk("abort w1 data", data, 8'h22);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort valid", valid, 1'b0);
    chk("abort busy", busy, 1'b0);
    chk("abort done", done, 1'b0);
    tick();
    chk("abort no late done", done, 1'b0);
    stream("after abort", 0, 1, -1, 8'h11, 8'h00, 8'h00, 8'h00);

    mem[DEPTH-2] = 8'hAA; mem[DEPTH-1] = 8'hBB;
    mem[0] = 8'hCC; mem[1] = 8'hDD;
    stream("wrap", ADDRW'(DEPTH - 2), 4, -1, 8'hAA, 8'hBB, 8'hCC, 8'hDD);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
